// File: rtl/modulo_contador_sync_param.sv
// Purpose     : parametrised up/down modulo counter with parallel load, terminal count and wrap/saturate mode.
// Latency     : one clock edge from enable/load to the new q; terminal is combinational on q and up_down.
// Backpressure: none; enable gates counting, and stages cascade through terminal into the next enable.
module modulo_contador_sync_param #(
   parameter int unsigned     WIDTH    = 7,
   parameter longint unsigned MODULO   = 128,
   parameter bit              SATURATE = 1'b0
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] q,
   output logic             terminal,
   output logic             carry_out
);

   // Reject parameter sets that cannot hold the requested count range.
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("modulo_contador_sync_param: WIDTH must be in 1..32");
   end
   if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
      $error("modulo_contador_sync_param: MODULO must be in 2..2**WIDTH");
   end

   // Highest reachable count; arithmetic is modulo MODULO, not 2**WIDTH.
   localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULO - 64'd1);
   localparam logic [WIDTH-1:0] ZERO_Q = '0;
   localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] q_up;
   logic [WIDTH-1:0] q_down;
   logic [WIDTH-1:0] q_next;
   logic             carry_next;

   // Boundary detection on the registered count, shared by terminal and next-state.
   always_comb begin
      at_max   = (q == MAX_Q);
      at_zero  = (q == ZERO_Q);
      terminal = up_down ? at_max : at_zero;
   end

   // Out-of-range load values clamp to the top of the count range.
   always_comb begin
      load_clamped = load_value;
      if (load_value > MAX_Q) begin
         load_clamped = MAX_Q;
      end
   end

   // Candidate values for each direction; the boundary either wraps or holds.
   always_comb begin
      q_up   = q + ONE_Q;
      q_down = q - ONE_Q;
      if (at_max) begin
         q_up = SATURATE ? q : ZERO_Q;
      end
      if (at_zero) begin
         q_down = SATURATE ? q : MAX_Q;
      end
   end

   // Priority load > enable > hold; carry flags a boundary crossing on an enabled count.
   always_comb begin
      q_next     = q;
      carry_next = 1'b0;
      if (load) begin
         q_next = load_clamped;
      end else if (enable) begin
         q_next     = up_down ? q_up : q_down;
         carry_next = terminal;
      end
   end

   // Count and carry registers; clear aborts any pending load or count immediately.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         q         <= '0;
         carry_out <= 1'b0;
      end else begin
         q         <= q_next;
         carry_out <= carry_next;
      end
   end

endmodule
